// File: rtl/aes_column_pingpong_buffer_pkg.sv
// -----------------------------------------------------------------------------
// aes_column_pingpong_buffer_pkg
// Shared AES column types and constants used by the ping-pong column buffer,
// plus a small bit-count helper used when the indexed-write build option
// (COLBUF_INDEXED_WRITE_EN) reports its fill level.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_column_pingpong_buffer_pkg;

  localparam int AES_BYTE_W    = 8;
  localparam int AES_COL_BYTES = 4;

  typedef logic [AES_BYTE_W-1:0]               aes_byte_t;
  typedef logic [AES_COL_BYTES*AES_BYTE_W-1:0] aes_col_t;

  // Number of set bits in v (masks up to 64 elements wide).
  function automatic int unsigned count_ones(input logic [63:0] v);
    int unsigned n;
    n = 32'd0;
    for (int k = 0; k < 64; k++) begin
      n = n + {31'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/aes_column_pingpong_buffer_if.sv
// -----------------------------------------------------------------------------
// aes_column_pingpong_buffer_if
// Handshake bundle for the ping-pong column buffer.
//   Load side : in_valid/in_ready byte stream with in_data, in_idx and flush.
//   Drain side: out_valid/out_ready column word out_data, plus fill_cnt.
// Modports:
//   master - the environment (producer + consumer) driving the buffer
//   slave  - the buffer itself
// -----------------------------------------------------------------------------
interface aes_column_pingpong_buffer_if
  import aes_column_pingpong_buffer_pkg::*;
#(
  parameter int BYTE_W = AES_BYTE_W,
  parameter int DEPTH  = AES_COL_BYTES
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [BYTE_W-1:0]       in_data;
  logic [IDX_W-1:0]        in_idx;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [DEPTH*BYTE_W-1:0] out_data;
  logic [IDX_W:0]          fill_cnt;

  modport master (
    output in_valid, in_data, in_idx, flush, out_ready,
    input  in_ready, out_valid, out_data, fill_cnt
  );

  modport slave (
    input  in_valid, in_data, in_idx, flush, out_ready,
    output in_ready, out_valid, out_data, fill_cnt
  );

endinterface

// File: rtl/aes_column_pingpong_buffer_colbuf_bank.sv
// -----------------------------------------------------------------------------
// colbuf_bank
// One column bank: DEPTH elements of BYTE_W bits with a single-element write
// port and a packed read of all elements (element k at [k*BYTE_W +: BYTE_W]).
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset (clears all elements)
//   clr   in  synchronous clear (same effect as rst)
//   we    in  write enable
//   widx  in  element index to write
//   wdata in  element data
//   rdata out packed contents of the bank
// -----------------------------------------------------------------------------
module colbuf_bank #(
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   widx,
  input  logic [BYTE_W-1:0]          wdata,
  output logic [DEPTH*BYTE_W-1:0]    rdata
);

  logic [BYTE_W-1:0] mem_r [DEPTH];

  // Element storage: cleared on reset/clear, otherwise one element per write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {BYTE_W{1'b0}};
      end
    end else if (we) begin
      mem_r[widx] <= wdata;
    end
  end

  // Packed read-out of every element.
  always_comb begin
    rdata = {(DEPTH*BYTE_W){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      rdata[k*BYTE_W +: BYTE_W] = mem_r[k];
    end
  end

endmodule

// File: rtl/aes_column_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// aes_column_pingpong_buffer
// Collects an AES column one byte per cycle into two ping-pong banks and
// presents each complete column as one packed word. One bank fills while the
// other waits to drain, sustaining one byte per cycle.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset (priority over everything)
//   bus  slave modport of aes_column_pingpong_buffer_if:
//        in_valid/in_ready/in_data/in_idx/flush  load side
//        out_valid/out_ready/out_data            drain side
//        fill_cnt                                elements in current write bank
// Build option:
//   COLBUF_INDEXED_WRITE_EN - bytes land at in_idx, tracked by a written mask;
//   the bank completes when every element has been written at least once.
//   Undefined: in_idx is ignored and elements fill strictly 0..DEPTH-1.
// All outputs are decoded from registered state only; there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module aes_column_pingpong_buffer
  import aes_column_pingpong_buffer_pkg::*;
#(
  parameter int BYTE_W = AES_BYTE_W,
  parameter int DEPTH  = AES_COL_BYTES
) (
  input  logic                          clk,
  input  logic                          rst,
  aes_column_pingpong_buffer_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int COL_W = DEPTH * BYTE_W;

  logic [1:0]       full_r;
  logic             wr_bank_r;
  logic             rd_bank_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;
  logic             complete_s;
  logic [IDX_W-1:0] widx_s;
  logic [1:0]       we_s;
  logic [COL_W-1:0] rdata0_s;
  logic [COL_W-1:0] rdata1_s;

`ifdef COLBUF_INDEXED_WRITE_EN
  logic [DEPTH-1:0] mask_r;
  logic [DEPTH-1:0] mask_nxt_s;
`else
  logic [IDX_W-1:0] wr_cnt_r;
  logic             unused_idx_s;
  assign unused_idx_s = ^bus.in_idx;
`endif

  // Handshake decode: write side stalls only when its target bank still holds
  // an undrained column; flush always wins over a same-cycle byte.
  always_comb begin
    in_ready_s = ~full_r[wr_bank_r];
    accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
    drain_s    = full_r[rd_bank_r] & bus.out_ready;
    we_s[0]    = accept_s & ~wr_bank_r;
    we_s[1]    = accept_s & wr_bank_r;
  end

`ifdef COLBUF_INDEXED_WRITE_EN
  // Indexed fill: the column is complete once every element has been written.
  always_comb begin
    widx_s     = bus.in_idx;
    mask_nxt_s = mask_r | (DEPTH'(1) << bus.in_idx);
    if (accept_s) begin
      complete_s = &mask_nxt_s;
    end else begin
      complete_s = 1'b0;
    end
  end
`else
  // Sequential fill: the column is complete on the DEPTH-th accepted byte.
  always_comb begin
    widx_s = wr_cnt_r;
    if (accept_s) begin
      complete_s = (wr_cnt_r == IDX_W'(DEPTH - 1));
    end else begin
      complete_s = 1'b0;
    end
  end
`endif

  // Bank pointers, full flags and fill progress. A completing fill and a drain
  // in the same cycle always touch different banks (one is empty, one full).
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
`ifdef COLBUF_INDEXED_WRITE_EN
      mask_r    <= {DEPTH{1'b0}};
`else
      wr_cnt_r  <= {IDX_W{1'b0}};
`endif
    end else begin
      if (bus.flush) begin
`ifdef COLBUF_INDEXED_WRITE_EN
        mask_r   <= {DEPTH{1'b0}};
`else
        wr_cnt_r <= {IDX_W{1'b0}};
`endif
      end else if (accept_s) begin
        if (complete_s) begin
          full_r[wr_bank_r] <= 1'b1;
          wr_bank_r         <= ~wr_bank_r;
`ifdef COLBUF_INDEXED_WRITE_EN
          mask_r            <= {DEPTH{1'b0}};
`else
          wr_cnt_r          <= {IDX_W{1'b0}};
`endif
        end else begin
`ifdef COLBUF_INDEXED_WRITE_EN
          mask_r            <= mask_nxt_s;
`else
          wr_cnt_r          <= wr_cnt_r + IDX_W'(1);
`endif
        end
      end
      if (drain_s) begin
        full_r[rd_bank_r] <= 1'b0;
        rd_bank_r         <= ~rd_bank_r;
      end
    end
  end

  colbuf_bank #(.BYTE_W(BYTE_W), .DEPTH(DEPTH)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .we    (we_s[0]),
    .widx  (widx_s),
    .wdata (bus.in_data),
    .rdata (rdata0_s)
  );

  colbuf_bank #(.BYTE_W(BYTE_W), .DEPTH(DEPTH)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .we    (we_s[1]),
    .widx  (widx_s),
    .wdata (bus.in_data),
    .rdata (rdata1_s)
  );

  // Drain-side word comes from the bank the read pointer selects; contents
  // stay visible after a drain because banks are never cleared on drain.
  always_comb begin
    if (rd_bank_r) begin
      bus.out_data = rdata1_s;
    end else begin
      bus.out_data = rdata0_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = full_r[rd_bank_r];
`ifdef COLBUF_INDEXED_WRITE_EN
  assign bus.fill_cnt  = (IDX_W+1)'(count_ones(64'(mask_r)));
`else
  assign bus.fill_cnt  = {1'b0, wr_cnt_r};
`endif

endmodule
